draw_frame_sync: RTL
====================

DRAW_FRAME_SYNC -- requirements
Module: draw_frame_sync

Interface
REQ-001 SHALL have parameter VS_POLARITY, default 1'b0, the active level of pix_vs_i.
REQ-002 SHALL have parameter BLINK_FRAMES, default 30, the number of frames per blink half-period (range 1..255).
REQ-003 SHALL have port clk_vga  in  1  pixel clock; the only clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port pix_vs_i  in  1  vertical sync from the VGA timing generator.
REQ-006 SHALL have port pix_de_i  in  1  display enable from the VGA timing generator.
REQ-007 SHALL have port upd_valid_i  in  1  game core offers a new game-data set.
REQ-008 SHALL have port upd_ready_o  out  1  update accepted this cycle when high together with upd_valid_i.
REQ-009 SHALL have input ports gd_*_i (field, score, lines, level, next_block_data/color/rotation/draw_en, game_over_state), with widths per defs.vh as on the draw path.
REQ-010 SHALL have output ports gd_*_o  out  same widths  snapshot presented to the draw path.
REQ-011 SHALL have port snap_valid_o  out  1  at least one snapshot taken since reset.
REQ-012 SHALL have port frame_cnt_o  out  16  frames counted since reset.
REQ-013 SHALL have port blink_o  out  1  blink phase; game_over_blink_o  out  1  equals gd_game_over_state_o AND blink_o.
REQ-014 SHALL have port late_o  out  1  one-cycle pulse when an update missed its window.

Function
REQ-015 SHALL detect the vs leading edge as pix_vs_i at VS_POLARITY while its 1-cycle delayed copy is not; the edge is usable in the cycle after it occurs.
REQ-016 SHALL implement the FSM states ACTIVE, BLANK and LOCK.
REQ-017 SHALL make the transition ACTIVE->BLANK on a vs leading edge.
REQ-018 SHALL make the transition BLANK->LOCK on a handshake.
REQ-019 SHALL make the transition BLANK->ACTIVE and LOCK->ACTIVE on a pix_de_i rising edge.
REQ-020 SHALL drive upd_ready_o = (state==BLANK) AND NOT pix_de_i, combinationally.
REQ-021 SHALL accept at most one handshake per frame.
REQ-022 SHALL update all gd_*_o from gd_*_i in the cycle after a handshake, atomically, and SHALL hold them otherwise.
REQ-023 SHALL give priority to pix_de_i when a handshake and pix_de_i rise in the same cycle: ready is 0, no capture, late_o pulses if upd_valid_i is high.
REQ-024 SHALL pulse late_o for 1 cycle when the state is BLANK on a pix_de_i rise with upd_valid_i high.
REQ-025 SHALL not pulse late_o in state LOCK.
REQ-026 SHALL set snap_valid_o to 1 at the first capture; it remains 1 until reset.
REQ-027 SHALL increment frame_cnt_o on each vs leading edge, modulo 2^16 (0xFFFF->0x0000).
REQ-028 SHALL maintain an 8-bit blink counter incrementing on each vs edge; on reaching BLINK_FRAMES-1, the counter returns to 0 and blink_o toggles on the same edge.
REQ-029 SHALL generate vs edges in every state; frame counting does not depend on handshakes.
REQ-030 SHALL make upd_valid_i alone never change the state.

Reset
REQ-031 SHALL, under rst, set: state ACTIVE, upd_ready_o 0, all gd_*_o 0, snap_valid_o 0, frame_cnt_o 0, blink counter 0, blink_o 0, late_o 0.
REQ-032 SHALL reset the vs delay register to VS_POLARITY, so a vs held active across reset release produces no edge.
REQ-033 SHALL, on reset asserted mid-BLANK, abandon the window; the next window opens only on the next vs leading edge.

Structure
REQ-034 SHALL place the state enum (ACTIVE/BLANK/LOCK) and the gd_snapshot_t struct grouping all gd_* fields in the shared package tetris_draw_pkg; field widths come from defs.vh macros.
REQ-035 SHALL contain one sub-module, frame_tick_gen, holding the vs edge detector, frame_cnt and the blink counter.
REQ-036 SHALL contain no other sub-modules.

Verification
REQ-037 SHALL cover: reset, then vs edge, then upd_valid held with score=0x000123 -> ready high from the cycle after the edge; gd_score_o=0x000123 and snap_valid_o=1 one cycle after the handshake.
REQ-038 SHALL cover: valid held across two blanks with data changing 5->7 between blanks -> exactly one capture per blank (5 then 7), and ready=0 in LOCK.
REQ-039 SHALL cover: valid first raised in the same cycle as the pix_de rise -> no capture, late_o single pulse, outputs unchanged.
REQ-040 SHALL cover: 65536 vs edges -> frame_cnt_o returns to 0x0000.
REQ-041 SHALL cover: BLINK_FRAMES=3 -> blink_o toggles on edges 3, 6, 9; game_over_blink_o follows only when game_over is captured as 1.
REQ-042 SHALL cover: rst pulsed inside BLANK while pix_vs held active -> state ACTIVE, ready 0, no window until the next vs leading edge.

Source files
------------

// File: rtl/tetris_draw_pkg.sv
// Shared types for the Tetris draw path: FSM states and the game-data
// snapshot handed from the game core to the renderer.
package tetris_draw_pkg;

    localparam int FIELD_W    = 200;
    localparam int SCORE_W    = 24;
    localparam int LINES_W    = 16;
    localparam int LEVEL_W    = 8;
    localparam int NB_DATA_W  = 16;
    localparam int NB_COLOR_W = 3;
    localparam int NB_ROT_W   = 2;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_BLANK,
        ST_LOCK
    } draw_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0]    field;
        logic [SCORE_W-1:0]    score;
        logic [LINES_W-1:0]    lines;
        logic [LEVEL_W-1:0]    level;
        logic [NB_DATA_W-1:0]  next_block_data;
        logic [NB_COLOR_W-1:0] next_block_color;
        logic [NB_ROT_W-1:0]   next_block_rotation;
        logic                  next_block_draw_en;
        logic                  game_over_state;
    } gd_snapshot_t;

endpackage

// File: rtl/draw_frame_sync_if.sv
// Game-core to draw-path update channel: valid/ready plus the game data.
interface draw_frame_sync_if;
    import tetris_draw_pkg::*;

    logic                  upd_valid_i;
    logic                  upd_ready_o;
    logic [FIELD_W-1:0]    gd_field_i;
    logic [SCORE_W-1:0]    gd_score_i;
    logic [LINES_W-1:0]    gd_lines_i;
    logic [LEVEL_W-1:0]    gd_level_i;
    logic [NB_DATA_W-1:0]  gd_next_block_data_i;
    logic [NB_COLOR_W-1:0] gd_next_block_color_i;
    logic [NB_ROT_W-1:0]   gd_next_block_rotation_i;
    logic                  gd_next_block_draw_en_i;
    logic                  gd_game_over_state_i;

    modport master (
        output upd_valid_i, gd_field_i, gd_score_i, gd_lines_i,
        output gd_level_i, gd_next_block_data_i, gd_next_block_color_i,
        output gd_next_block_rotation_i, gd_next_block_draw_en_i,
        output gd_game_over_state_i,
        input  upd_ready_o
    );

    modport slave (
        input  upd_valid_i, gd_field_i, gd_score_i, gd_lines_i,
        input  gd_level_i, gd_next_block_data_i, gd_next_block_color_i,
        input  gd_next_block_rotation_i, gd_next_block_draw_en_i,
        input  gd_game_over_state_i,
        output upd_ready_o
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Vertical-sync leading-edge detector with a free-running frame counter
// and a blink phase generator.
module frame_tick_gen #(
    parameter logic VS_POLARITY  = 1'b0,
    parameter int   BLINK_FRAMES = 30
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        pix_vs_i,
    output logic        vs_edge_o,
    output logic [15:0] frame_cnt_o,
    output logic        blink_o
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic        vs_q, vs_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;

    assign vs_edge_o = (pix_vs_i == VS_POLARITY) && (vs_q != VS_POLARITY);

    always_comb begin
        vs_d        = pix_vs_i;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (vs_edge_o) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    // vs delay resets to the active level so a vs held across reset is no edge
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            vs_q        <= VS_POLARITY;
            frame_cnt_q <= 16'd0;
            blink_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
        end else begin
            vs_q        <= vs_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign blink_o     = blink_q;

endmodule

// File: rtl/draw_frame_sync.sv
// Latches one game-data snapshot per frame during vertical blanking so the
// draw path never sees a half-updated game state.
module draw_frame_sync
    import tetris_draw_pkg::*;
#(
    parameter logic VS_POLARITY  = 1'b0,
    parameter int   BLINK_FRAMES = 30
) (
    input  logic                  clk_vga,
    input  logic                  rst,
    input  logic                  pix_vs_i,
    input  logic                  pix_de_i,
    draw_frame_sync_if.slave      upd,
    output logic [FIELD_W-1:0]    gd_field_o,
    output logic [SCORE_W-1:0]    gd_score_o,
    output logic [LINES_W-1:0]    gd_lines_o,
    output logic [LEVEL_W-1:0]    gd_level_o,
    output logic [NB_DATA_W-1:0]  gd_next_block_data_o,
    output logic [NB_COLOR_W-1:0] gd_next_block_color_o,
    output logic [NB_ROT_W-1:0]   gd_next_block_rotation_o,
    output logic                  gd_next_block_draw_en_o,
    output logic                  gd_game_over_state_o,
    output logic                  snap_valid_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  blink_o,
    output logic                  game_over_blink_o,
    output logic                  late_o
);

    draw_state_e  state_q, state_d;
    gd_snapshot_t snap_q, snap_d, gd_in;
    logic         snap_valid_q, snap_valid_d;
    logic         late_q, late_d;
    logic         de_q, de_d;
    logic         vs_edge, de_rise, ready, hs;

    frame_tick_gen #(
        .VS_POLARITY (VS_POLARITY),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_tick (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .pix_vs_i   (pix_vs_i),
        .vs_edge_o  (vs_edge),
        .frame_cnt_o(frame_cnt_o),
        .blink_o    (blink_o)
    );

    assign gd_in.field               = upd.gd_field_i;
    assign gd_in.score               = upd.gd_score_i;
    assign gd_in.lines               = upd.gd_lines_i;
    assign gd_in.level               = upd.gd_level_i;
    assign gd_in.next_block_data     = upd.gd_next_block_data_i;
    assign gd_in.next_block_color    = upd.gd_next_block_color_i;
    assign gd_in.next_block_rotation = upd.gd_next_block_rotation_i;
    assign gd_in.next_block_draw_en  = upd.gd_next_block_draw_en_i;
    assign gd_in.game_over_state     = upd.gd_game_over_state_i;

    // de dominates: a window closing this cycle can no longer accept data
    assign ready   = !rst && (state_q == ST_BLANK) && !pix_de_i;
    assign hs      = upd.upd_valid_i && ready;
    assign de_rise = pix_de_i && !de_q;

    assign upd.upd_ready_o = ready;

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        late_d       = 1'b0;
        de_d         = pix_de_i;
        if (hs) begin
            snap_d       = gd_in;
            snap_valid_d = 1'b1;
        end
        unique case (state_q)
            ST_ACTIVE: begin
                if (vs_edge) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                if (de_rise) begin
                    state_d = ST_ACTIVE;
                    late_d  = upd.upd_valid_i;
                end else if (hs) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (de_rise) state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q      <= ST_ACTIVE;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            late_q       <= 1'b0;
            de_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            late_q       <= late_d;
            de_q         <= de_d;
        end
    end

    assign gd_field_o               = snap_q.field;
    assign gd_score_o               = snap_q.score;
    assign gd_lines_o               = snap_q.lines;
    assign gd_level_o               = snap_q.level;
    assign gd_next_block_data_o     = snap_q.next_block_data;
    assign gd_next_block_color_o    = snap_q.next_block_color;
    assign gd_next_block_rotation_o = snap_q.next_block_rotation;
    assign gd_next_block_draw_en_o  = snap_q.next_block_draw_en;
    assign gd_game_over_state_o     = snap_q.game_over_state;
    assign snap_valid_o             = snap_valid_q;
    assign game_over_blink_o        = snap_q.game_over_state && blink_o;
    assign late_o                   = late_q;

endmodule
